// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the 1-to-4 demultiplexer
//
// Purpose : port count, select width, holding-stage state encoding and a
//           2-bit to 4-bit one-hot helper shared by demux_1_4 and dec_2_4.
// Ports   : none (package).

package demux_pkg;

    localparam int NPORT = 4;
    localparam int SELW  = 2;

    // Holding-stage occupancy; a single flag is the whole state machine.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic logic [NPORT-1:0] onehot4(input logic [SELW-1:0] sel);
        logic [NPORT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_1_4_dec.sv
// rtl/demux_1_4_dec.sv - combinational 2-to-4 one-hot decoder with enable
//
// Purpose : y is one-hot(sel) when en is high, all zero otherwise.
// Ports   : en  - decode enable
//           sel - 2-bit index
//           y   - 4-bit one-hot result

module dec_2_4
    import demux_pkg::*;
(
    input  logic            en,
    input  logic [SELW-1:0] sel,
    output logic [NPORT-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = onehot4(sel);
        end
    end

endmodule

// File: rtl/demux_1_4.sv
// rtl/demux_1_4.sv - registered 1-to-4 demultiplexer with valid/ready handshake
//
// Purpose : buffers one upstream beat in a single-entry stage and presents it
//           to the destination chosen by its select; counts delivered beats
//           per destination.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-high reset
//           in_valid  - upstream beat present
//           in_ready  - beat accepted this cycle
//           in_sel    - destination index 0..3
//           in_data   - beat payload
//           out_valid - one-hot destination of the held beat
//           out_ready - per-destination ready
//           out_data  - held payload, shared by all destinations
//           cnt       - delivered-beat counters, port k at [k*cw +: cw]

module demux_1_4
    import demux_pkg::*;
#(
    parameter int w  = 32,
    parameter int cw = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   in_sel,
    input  logic [w-1:0]      in_data,
    output logic [NPORT-1:0]  out_valid,
    input  logic [NPORT-1:0]  out_ready,
    output logic [w-1:0]      out_data,
    output logic [NPORT*cw-1:0] cnt
);

    logic [0:0]      full;
    logic [w-1:0]    data_q;
    logic [SELW-1:0] sel_q;

    logic [0:0]      full_d;
    logic [w-1:0]    data_d;
    logic [SELW-1:0] sel_d;

    logic            deliver;
    logic            accept;
    logic [NPORT-1:0] inc;

    // Only the ready of the held beat's destination can drain it.
    assign deliver  = (full == ST_FULL) && out_ready[sel_q];

    // Pass-through refill: a draining stage can take a new beat at the same
    // edge, which is what sustains one beat per cycle.
    assign in_ready = (full == ST_EMPTY) || out_ready[sel_q];
    assign accept   = in_valid && in_ready;

    assign out_data = data_q;

    dec_2_4 u_dec_valid (
        .en  (full == ST_FULL),
        .sel (sel_q),
        .y   (out_valid)
    );

    dec_2_4 u_dec_inc (
        .en  (deliver),
        .sel (sel_q),
        .y   (inc)
    );

    always_comb begin
        full_d = full;
        data_d = data_q;
        sel_d  = sel_q;
        if (accept) begin
            // Covers both an empty-stage load and a same-edge reload.
            full_d = ST_FULL;
            data_d = in_data;
            sel_d  = in_sel;
        end else if (deliver) begin
            full_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= ST_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            full   <= full_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

    // Counters advance on delivery only and wrap freely.
    for (genvar k = 0; k < NPORT; k++) begin : g_cnt
        logic [cw-1:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (inc[k]) begin
                cnt_q <= cnt_q + cw'(1);
            end
        end

        assign cnt[k*cw +: cw] = cnt_q;
    end

endmodule

// File: tb/tb_demux_1_4.sv
// tb/tb_demux_1_4.sv - self-checking bench for demux_1_4

module tb_demux_1_4;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic [W-1:0]  in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data;
    logic [4*CW-1:0] cnt;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } beat_t;

    beat_t         sb[$];
    logic [CW-1:0] mcnt [4];
    int            checks;
    int            errors;
    int            deliveries;

    demux_1_4 #(.w(W), .cw(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] s);
        logic [3:0] v;
        v = 4'b0001 << s;
        return v;
    endfunction

    function automatic logic [4*CW-1:0] model_cnt();
        return {mcnt[3], mcnt[2], mcnt[1], mcnt[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [W-1:0] d);
        beat_t b;
        b.sel  = s;
        b.data = d;
        sb.push_back(b);
    endtask

    // Called with inputs already driven after a falling edge. Any handshake
    // visible on the outputs before the rising edge is a delivery and must
    // match the oldest beat the bench has sent.
    task automatic tick();
        beat_t e;
        #1;
        if ((out_valid & out_ready) != 4'b0000) begin
            deliveries++;
            if (sb.size() == 0) begin
                chk("spurious_delivery", {60'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("dlv_valid", {60'd0, out_valid}, {60'd0, oh(e.sel)});
                chk("dlv_data", {32'd0, out_data}, {32'd0, e.data});
                mcnt[e.sel] = mcnt[e.sel] + 8'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        int           dlv0;

        checks     = 0;
        errors     = 0;
        deliveries = 0;
        for (int k = 0; k < 4; k++) mcnt[k] = '0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_cnt", {32'd0, cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single beat to port 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
        #1 chk("single_in_ready", {63'd0, in_ready}, 64'd1);
        push(2'd2, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0;
        #1;
        chk("single_out_valid", {60'd0, out_valid}, 64'h4);
        chk("single_out_data", {32'd0, out_data}, 64'hDEADBEEF);
        out_ready = 4'b0100;
        tick();
        chk("single_empty", {60'd0, out_valid}, 64'd0);
        chk("single_cnt2", {32'd0, cnt}, {32'd0, 8'd0, 8'd1, 8'd0, 8'd0});
        chk("single_sb", sb.size(), 64'd0);

        // Backpressure on port 1
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hA5A5_0101;
        push(2'd1, 32'hA5A5_0101);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {60'd0, out_valid}, 64'h2);
            chk("bp_out_data", {32'd0, out_data}, 64'hA5A5_0101);
            chk("bp_cnt", {32'd0, cnt}, {32'd0, model_cnt()});
            tick();
        end
        dlv0 = deliveries;
        out_ready = 4'b0010;
        tick();
        tick();
        chk("bp_once", deliveries - dlv0, 64'd1);
        chk("bp_cnt_after", {32'd0, cnt}, {32'd0, 8'd0, 8'd1, 8'd1, 8'd0});

        // Streaming, one beat per cycle rotating over all ports
        out_ready = 4'b1111;
        dlv0 = deliveries;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            in_valid = 1'b1; in_sel = 2'(i % 4); in_data = d;
            #1;
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i > 0) chk("stream_rotate", {60'd0, out_valid}, {60'd0, oh(2'((i - 1) % 4))});
            push(2'(i % 4), d);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("stream_deliveries", deliveries - dlv0, 64'd8);
        chk("stream_cnt", {32'd0, cnt}, {32'd0, 8'd2, 8'd3, 8'd3, 8'd2});

        // Wrap-around of port 3 counter: 2 + 257 deliveries wraps to 3
        out_ready = 4'b1000;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 32'(i);
            push(2'd3, 32'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt3", {56'd0, cnt[3*CW +: CW]}, 64'd3);
        chk("wrap_cnt", {32'd0, cnt}, {32'd0, model_cnt()});

        // Ready on non-selected ports must not drain a port 2 beat
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h0000_2222;
        push(2'd2, 32'h0000_2222);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nsel_out_valid", {60'd0, out_valid}, 64'h4);
            chk("nsel_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        chk("nsel_held", sb.size(), 64'd1);
        chk("nsel_cnt", {32'd0, cnt}, {32'd0, model_cnt()});
        out_ready = 4'b0100;
        tick();
        chk("nsel_drained", sb.size(), 64'd0);

        // Asynchronous reset while a port 0 beat is held
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0BAD_F00D;
        push(2'd0, 32'h0BAD_F00D);
        tick();
        in_valid = 1'b0;
        #1 chk("mid_held", {60'd0, out_valid}, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_out_valid", {60'd0, out_valid}, 64'd0);
        chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_cnt0", {56'd0, cnt[0 +: CW]}, 64'd0);
        chk("mid_cnt", {32'd0, cnt}, 64'd0);
        sb.delete();
        for (int k = 0; k < 4; k++) mcnt[k] = '0;
        #1 rst = 1'b0;
        @(negedge clk);

        // First cycle after reset release accepts a beat
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1234_5678;
        #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        push(2'd1, 32'h1234_5678);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0010;
        tick();
        chk("post_rst_cnt", {32'd0, cnt}, {32'd0, 8'd0, 8'd0, 8'd1, 8'd0});
        chk("final_sb", sb.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_4.md
# demux_1_4

Registered 1-to-4 demultiplexer with a valid/ready handshake. It is the steering counterpart of the SoC's 4:1 word multiplexer. A single upstream producer, such as the datapath write port, sends one word per beat with a 2-bit destination select. The block buffers the beat in a one-entry output stage and presents it to exactly one of four downstream consumers, such as peripheral or memory write ports. It also keeps a per-destination delivered-beat count for debug and verification.

## Interface
Parameters:
- w, 32: data width in bits.
- cw, 8: width of each per-destination delivered-beat counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_sel  input  2  destination index 0..3, sampled with the beat.
- in_data  input  w  beat payload.
- out_valid  output  4  one-hot; bit k is set when the held beat is destined for port k.
- out_ready  input  4  per-destination ready.
- out_data  output  w  held payload, shared by all four ports; meaningful only where out_valid is set.
- cnt  output  4*cw  delivered-beat counters; port k occupies bits [k*cw +: cw].

## Operation
- Storage: a one-entry holding stage made of data_q[w], sel_q[2] and a full flag.
- State machine:
  - EMPTY (full=0):
    - in_ready=1.
    - When in_valid is high: capture in_data and in_sel, then go to FULL.
  - FULL (full=1):
    - out_valid = one-hot(sel_q); out_data = data_q.
    - A delivery occurs when out_ready[sel_q] is high.
    - in_ready = out_ready[sel_q]. This is a pass-through refill: a new beat may be accepted in the same cycle the held beat drains.
    - Delivery with in_valid high: reload with the new beat and stay in FULL.
    - Delivery with in_valid low: go to EMPTY.
    - No delivery: hold all state.
- Only out_ready[sel_q] matters. The other out_ready bits are ignored, and a ready on a non-selected port never causes a delivery.
- out_valid is never multi-hot. It is all zero in EMPTY.
- Acceptance rule: a beat is accepted exactly when in_valid and in_ready are both high. Producers may not withdraw an unaccepted beat; the block does not check this.
- Counter cnt[k]:
  - Increments by 1 on each delivery to port k.
  - Wraps modulo 2^cw, e.g. 2^cw−1 → 0, with no saturation and no sticky flag.
  - Counters change only on delivery, never on acceptance.
- in_ready has a combinational path from out_ready. There is no combinational path from in_valid, in_sel or in_data to any output.

## Timing
- Reset, asynchronous and applied immediately:
  - full=0, data_q=0, sel_q=0, all cnt=0.
  - Outputs during reset: out_valid=4'b0000, out_data=0, in_ready=1.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N. Its earliest delivery is the cycle following N.
- Throughput: one beat per cycle when the selected consumer holds ready.
- Back-to-back beats to different ports: the drain of port A and the accept of a beat for port B occur at the same edge. out_valid switches one-hot from A to B with no idle cycle.
- Reset asserted mid-operation: a held, undelivered beat is discarded, no counter increments, and the block returns to EMPTY.
- Reset deassertion needs no recovery cycle. A beat presented in the first cycle after deassertion is accepted.

## Structure
- Shared package demux_pkg:
  - NPORT=4 and SELW=2.
  - A function onehot4(sel) returning a 4-bit one-hot vector.
- One sub-module, dec_2_4:
  - Combinational 2-to-4 one-hot decoder with an enable input.
  - Drives out_valid (enable=full) and generates the per-port counter increment strobes (enable = full & out_ready[sel_q]).
- Counters: four cw-bit registers inside demux_1_4, concatenated onto cnt.

## Test plan
- Reset and single beat:
  - Assert rst, then release.
  - Check out_valid=0000, in_ready=1, cnt=0.
  - Send in_sel=2, in_data=32'hDEADBEEF.
  - Next cycle: out_valid=0100, out_data=DEADBEEF.
  - Set out_ready=0100: the beat is delivered, cnt[2]=1, and the block returns to EMPTY.
- Backpressure:
  - Hold a beat for port 1 while out_ready=1101 (port 1 not ready) for 5 cycles.
  - Check in_ready=0, out_valid stays 0010, data is stable, and no counter changes.
  - Raise out_ready[1]: the beat is delivered exactly once.
- Streaming:
  - Send 8 back-to-back beats with sel 0,1,2,3,0,1,2,3 while out_ready=1111.
  - Check one delivery per cycle, out_valid rotates 0001→0010→0100→1000, and the final cnt is 2 on every port.
- Wrap-around: with cw=8, deliver 257 beats to port 3 and check cnt[3]=1.
- Reset mid-operation:
  - Hold a beat for port 0 with out_ready=0, then pulse rst asynchronously between edges.
  - Check out_valid drops to 0 immediately, cnt[0] stays 0, and in_ready=1.
- Non-selected ready: hold a beat for port 2 with out_ready=1011 and check that it is not delivered and no counter changes.
